// File: rtl/axi_wr_sched.sv
// AXI write-path scheduler: round-robin AW arbitration with grant lock,
// in-order W forwarding through a grant-order FIFO, B routing by index,
// and a cap on outstanding write transactions. Handshakes/selects only.
module axi_wr_sched #(
    parameter int NUM_REQ         = 4,
    parameter int MAX_OUTSTANDING = 8,
    parameter int IDX_W           = $clog2(NUM_REQ),
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_aw_valid_i,
    output logic [NUM_REQ-1:0] req_aw_ready_o,
    output logic               mst_aw_valid_o,
    input  logic               mst_aw_ready_i,
    output logic [IDX_W-1:0]   aw_sel_o,
    input  logic [NUM_REQ-1:0] req_w_valid_i,
    output logic [NUM_REQ-1:0] req_w_ready_o,
    output logic               mst_w_valid_o,
    input  logic               mst_w_ready_i,
    input  logic               mst_w_last_i,
    output logic [IDX_W-1:0]   w_sel_o,
    input  logic               mst_b_valid_i,
    output logic               mst_b_ready_o,
    input  logic [IDX_W-1:0]   b_sel_i,
    output logic [NUM_REQ-1:0] req_b_valid_o,
    input  logic [NUM_REQ-1:0] req_b_ready_i
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [IDX_W-1:0] rr_q, lock_idx_q;
    logic             lock_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] fifo_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] occ_q;

    logic [IDX_W-1:0] winner, win_hi, win_lo, head;
    logic             found, found_hi, found_lo;
    logic             cap_hit, fifo_empty;
    logic             aw_hs, w_pop, b_hs;

    // Round-robin pick: lowest valid at/after rr_q, else wrap to lowest valid; lock overrides
    always_comb begin
        win_hi   = '0;
        win_lo   = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_aw_valid_i[i]) begin
                win_lo   = IDX_W'(i);
                found_lo = 1'b1;
                if (i >= int'(rr_q)) begin
                    win_hi   = IDX_W'(i);
                    found_hi = 1'b1;
                end
            end
        end
        if (lock_q) begin
            winner = lock_idx_q;
            found  = 1'b1;
        end else begin
            winner = found_hi ? win_hi : win_lo;
            found  = found_lo;
        end
    end

    // AW handshake steering, gated while the outstanding cap is reached
    always_comb begin
        cap_hit        = (cnt_q == CNT_W'(MAX_OUTSTANDING));
        mst_aw_valid_o = found && !cap_hit;
        aw_sel_o       = winner;
        aw_hs          = mst_aw_valid_o && mst_aw_ready_i;
        req_aw_ready_o = '0;
        for (int i = 0; i < NUM_REQ; i++)
            req_aw_ready_o[i] = aw_hs && (winner == IDX_W'(i));
    end

    // W steering from the head of the grant-order FIFO; no bypass
    always_comb begin
        fifo_empty    = (occ_q == '0);
        head          = fifo_mem[rd_ptr_q];
        w_sel_o       = fifo_empty ? '0 : head;
        mst_w_valid_o = 1'b0;
        req_w_ready_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!fifo_empty && head == IDX_W'(i)) begin
                mst_w_valid_o    = req_w_valid_i[i];
                req_w_ready_o[i] = mst_w_ready_i;
            end
        end
        w_pop = mst_w_valid_o && mst_w_ready_i && mst_w_last_i;
    end

    // B routing; an out-of-range index is accepted and dropped
    always_comb begin
        mst_b_ready_o = 1'b1;
        req_b_valid_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (b_sel_i == IDX_W'(i)) begin
                req_b_valid_o[i] = mst_b_valid_i;
                mst_b_ready_o    = req_b_ready_i[i];
            end
        end
        b_hs = mst_b_valid_i && mst_b_ready_o;
    end

    // Round-robin pointer and grant lock
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else if (aw_hs) begin
            rr_q   <= (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            lock_q <= 1'b0;
        end else if (mst_aw_valid_o) begin
            lock_q     <= 1'b1;
            lock_idx_q <= winner;
        end
    end

    // Outstanding counter; B on zero saturates
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt_q <= '0;
        else if (aw_hs && !b_hs)
            cnt_q <= cnt_q + 1'b1;
        else if (b_hs && !aw_hs && cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
    end

    // Grant-order FIFO pointers and occupancy
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (aw_hs)
                wr_ptr_q <= (wr_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + 1'b1;
            if (w_pop)
                rd_ptr_q <= (rd_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + 1'b1;
            if (aw_hs && !w_pop)
                occ_q <= occ_q + 1'b1;
            else if (w_pop && !aw_hs)
                occ_q <= occ_q - 1'b1;
        end
    end

    // FIFO storage; contents are meaningless while empty so no reset
    always_ff @(posedge clk_i) begin
        if (aw_hs)
            fifo_mem[wr_ptr_q] <= winner;
    end

endmodule
